mul_rr_arbiter: RTL and testbench
=================================

Name: mul_rr_arbiter

Overview:
- Shares one pipelined signed 32x32 multiplier between N requesters.
- Each requester uses a valid/ready operand handshake; the block arbitrates round-robin and drives the winner's operands into the multiplier.
- It tracks the owner of every in-flight product and steers each 64-bit result back with a one-hot valid and requester ID.
- It sits between the requesting datapath units and the shared multiplier instance.

Parameters:
- N, 4, number of requesters (2..16)
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= N
- LATENCY, 2, cycles from operand presentation on mul_x/mul_y to a valid product on mul_z (multiplier has input and output registers)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- enable  input  1  1 = grants allowed; 0 = no new grants, in-flight ops still complete
- req_valid  input  N  per-requester operand valid
- req_x  input  N*32  signed X operands, requester i at bits [32i+31:32i]
- req_y  input  N*32  signed Y operands, same packing
- req_ready  output  N  one-hot grant; handshake when req_valid[i] & req_ready[i]
- mul_x  output  32  operand X to shared multiplier
- mul_y  output  32  operand Y to shared multiplier
- mul_z  input  64  signed product from shared multiplier
- rsp_valid  output  N  one-hot result valid
- rsp_id  output  IDW  index of result owner
- rsp_z  output  64  signed product for owner
- busy  output  1  1 while any operation is in flight

Behaviour:
- Reset (rst=0, async): rr_ptr=0; all tag stages invalid and id 0. Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, busy=0, mul_x=mul_y=0.
- Arbitration (combinational from registered rr_ptr): when enable=1, the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
- req_ready is one-hot for the winner and all-zero if enable=0 or no request is pending.
- Because req_ready depends only on req_valid, rr_ptr and enable, a requester holding req_valid is granted within N cycles while enable=1.
- Requester rule: once req_valid is asserted, req_x/req_y must be held stable until the handshake.
- On a handshake by requester w: rr_ptr <= (w+1) mod N at the clock edge; with no handshake, rr_ptr holds.
- mul_x/mul_y are combinationally the winner's operands, forced to 0 when there is no grant.
- Tag pipeline: LATENCY stages of {valid, id}. Stage 1 loads {handshake, w} each cycle; stage k loads stage k-1.
- Timing: a handshake in cycle t makes stage LATENCY valid in cycle t+LATENCY, the cycle mul_z carries that product.
- Response, combinational from stage LATENCY:
  - rsp_valid = onehot(id) if stage valid, else 0.
  - rsp_id = id if valid, else 0.
  - rsp_z = mul_z if valid, else 0.
  - No response backpressure: requesters must accept rsp_valid when it is asserted.
- Throughput: one issue per cycle. Back-to-back grants yield back-to-back responses in issue order.
- busy = OR of all tag-stage valid bits.
- enable falling mid-stream: no new handshakes; in-flight tags drain and responses still appear; rr_ptr is frozen.
- Requester dropping req_valid while not granted: legal; no side effects.
- Reset asserted mid-operation: all in-flight tags are discarded and their results never produce rsp_valid. Requesters must reissue after reset.
- Arithmetic: the product is the full signed 64-bit result from the multiplier, passed through unmodified. No truncation or saturation in this block.
- N=1: the grant degenerates to req_ready = req_valid & enable; rr_ptr stays 0.

Test Plan:
- Reset, then single request: req_valid=0001, x=-3, y=7 in cycle t -> req_ready=0001 in t; rsp_valid=0001, rsp_id=0, rsp_z=-21 in t+2; busy=1 in t+1..t+2.
- All four requesters asserted continuously with x=i+1, y=10 -> grant order 0,1,2,3,0,...; responses 10,20,30,40 on consecutive cycles with matching rsp_id.
- Fairness: requesters 0 and 2 always valid -> grants alternate 0,2,0,2; never two consecutive grants to the same requester.
- Extremes: x=0x80000000, y=0x80000000 -> rsp_z=0x4000000000000000; x=0x7FFFFFFF, y=-1 -> rsp_z=0xFFFFFFFF80000001.
- enable dropped in the cycle after a grant -> no further req_ready; the in-flight result still returns; busy falls after the drain; on re-enable, arbitration resumes from the saved rr_ptr.
- rst pulsed low one cycle after issuing two ops -> rsp_valid stays 0 for both; rr_ptr=0, so requester 0 wins first after release.

Source files
------------

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: shares one pipelined signed 32x32 multiplier among N
// requesters. A round-robin arbiter picks one valid requester per cycle and
// drives its operands onto mul_x/mul_y. A LATENCY-deep tag pipeline remembers
// who owns each in-flight product, so the product on mul_z can be steered
// back to its owner.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   enable              1 = new grants allowed (in-flight ops always drain)
//   req_valid/req_ready per-requester operand handshake (ready is one-hot)
//   req_x, req_y        packed operands, requester i at [32i+31:32i]
//   mul_x, mul_y        winner operands to the multiplier (0 when idle)
//   mul_z               product from the multiplier, LATENCY cycles later
//   rsp_valid/id/z      one-hot result valid, owner index, product
//   busy                any tag stage valid

// Per-requester slice: grant decode, operand masking, response decode.
module mul_rr_lane #(
  parameter int IDX = 0,
  parameter int IDW = 2
) (
  input  logic           gnt,
  input  logic [IDW-1:0] win_id,
  input  logic [31:0]    x,
  input  logic [31:0]    y,
  input  logic           rsp_vld,
  input  logic [IDW-1:0] rsp_id_in,
  output logic           ready,
  output logic [31:0]    x_m,
  output logic [31:0]    y_m,
  output logic           rsp_hit
);
  assign ready   = gnt && (win_id == IDW'(IDX));
  // Only the winner contributes, so the top can OR-reduce lane operands.
  assign x_m     = ready ? x : '0;
  assign y_m     = ready ? y : '0;
  assign rsp_hit = rsp_vld && (rsp_id_in == IDW'(IDX));
endmodule

module mul_rr_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [N-1:0]    req_valid,
  input  logic [N*32-1:0] req_x,
  input  logic [N*32-1:0] req_y,
  output logic [N-1:0]    req_ready,
  output logic [31:0]     mul_x,
  output logic [31:0]     mul_y,
  input  logic [63:0]     mul_z,
  output logic [N-1:0]    rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [63:0]     rsp_z,
  output logic            busy
);
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           gnt;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   idx;

  logic [LATENCY:1]          vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][IDW-1:0] id_pipe_q, id_pipe_d;

  logic [N-1:0][31:0] lane_x, lane_y;

  // Scan rr_ptr, rr_ptr+1, ... mod N; first valid requester wins. Grants are
  // suppressed while reset is asserted so req_ready reads 0 in reset.
  always_comb begin
    gnt    = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (!gnt && enable && rst && req_valid[i] && idx == (IDW+1)'(i)) begin
          gnt    = 1'b1;
          win_id = IDW'(i);
        end
      end
    end
  end

  // Every grant is a handshake: ready is only raised toward a valid requester.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt) rr_ptr_d = (win_id == IDW'(N-1)) ? '0 : win_id + IDW'(1);
  end

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[1] = gnt;
    id_pipe_d[1]  = win_id;
    for (int k = 2; k <= LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      id_pipe_d[k]  = id_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mul_rr_lane #(.IDX(i), .IDW(IDW)) u_lane (
      .gnt       (gnt),
      .win_id    (win_id),
      .x         (req_x[32*i +: 32]),
      .y         (req_y[32*i +: 32]),
      .rsp_vld   (vld_pipe_q[LATENCY]),
      .rsp_id_in (id_pipe_q[LATENCY]),
      .ready     (req_ready[i]),
      .x_m       (lane_x[i]),
      .y_m       (lane_y[i]),
      .rsp_hit   (rsp_valid[i])
    );
  end

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    for (int i = 0; i < N; i++) begin
      mul_x = mul_x | lane_x[i];
      mul_y = mul_y | lane_y[i];
    end
  end

  assign rsp_id = vld_pipe_q[LATENCY] ? id_pipe_q[LATENCY] : '0;
  assign rsp_z  = vld_pipe_q[LATENCY] ? mul_z : '0;
  assign busy   = |vld_pipe_q;
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Directed bench for mul_rr_arbiter with a 2-stage multiplier model and a
// scoreboard of expected responses keyed by due cycle.
module tb_mul_rr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst, enable;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*32-1:0] req_x, req_y;
  logic [31:0]     mul_x, mul_y;
  logic [63:0]     mul_z, rsp_z;
  logic [IDW-1:0]  rsp_id;
  logic            busy;

  always #5 clk = ~clk;

  mul_rr_arbiter #(.N(N), .IDW(IDW), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Shared multiplier: input register then output register.
  logic [31:0] mx_q, my_q;
  logic [63:0] mz_q;
  always_ff @(posedge clk) begin
    mx_q <= mul_x;
    my_q <= mul_y;
    mz_q <= smul(mx_q, my_q);
  end
  assign mul_z = mz_q;

  typedef struct { int due; int id; logic [63:0] z; } ent_t;
  ent_t        q[$];
  int          hist[$];
  logic [31:0] tx[N], ty[N];
  int          cyc, m_ptr, n_pass, n_total;
  bit          hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive operands, check at negedge against the model, advance.
  task automatic step();
    int w;
    logic [N-1:0] one, exp_rdy;
    ent_t e;
    for (int i = 0; i < N; i++) begin
      req_x[32*i +: 32] = tx[i];
      req_y[32*i +: 32] = ty[i];
    end
    @(negedge clk);
    w = -1;
    if (enable && rst) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req_valid[c]) w = c;
      end
    end
    one     = 1;
    exp_rdy = (w >= 0) ? one << w : '0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("mul_x", 64'(mul_x), (w >= 0) ? 64'(tx[w]) : 64'd0);
    chk("mul_y", 64'(mul_y), (w >= 0) ? 64'(ty[w]) : 64'd0);
    chk("busy", 64'(busy), 64'(q.size() > 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(one << e.id));
      chk("rsp_id", 64'(rsp_id), 64'(e.id));
      chk("rsp_z", rsp_z, e.z);
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      chk("rsp_z_idle", rsp_z, 64'd0);
    end
    if (w >= 0) begin
      q.push_back('{cyc + 2, w, smul(tx[w], ty[w])});
      m_ptr = (w + 1) % N;
      hist.push_back(w);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (w >= 0 && !hold) req_valid[w] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; m_ptr = 0; hold = 0;
    for (int i = 0; i < N; i++) begin tx[i] = '0; ty[i] = '0; end
    rst = 1'b0; enable = 1'b1; req_valid = 4'b0001;

    // Reset: outputs quiet even with a request pending
    repeat (2) step();
    req_valid = '0; rst = 1'b1;
    step();

    // Single request -3 * 7
    tx[0] = 32'hFFFF_FFFD; ty[0] = 32'd7; req_valid = 4'b0001;
    repeat (4) step();
    chk("single_const", smul(32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);

    // All four continuously valid, x=i+1, y=10
    for (int i = 0; i < N; i++) begin tx[i] = 32'(i + 1); ty[i] = 32'd10; end
    hold = 1; req_valid = 4'hF;
    repeat (8) step();
    req_valid = '0; hold = 0;
    repeat (3) step();

    // Fairness: 0 and 2 always valid
    hist.delete();
    hold = 1; req_valid = 4'b0101;
    repeat (6) step();
    req_valid = '0; hold = 0;
    repeat (3) step();
    chk("fair_count", 64'(hist.size()), 64'd6);
    for (int k = 1; k < hist.size(); k++) chk("fair_alt", 64'(hist[k] != hist[k-1]), 64'd1);

    // Signed extremes
    tx[1] = 32'h8000_0000; ty[1] = 32'h8000_0000;
    tx[3] = 32'h7FFF_FFFF; ty[3] = 32'hFFFF_FFFF;
    req_valid = 4'b1010;
    repeat (5) step();
    chk("ext_min", smul(32'h8000_0000, 32'h8000_0000), 64'h4000_0000_0000_0000);
    chk("ext_max", smul(32'h7FFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0001);

    // enable dropped after one grant; drain, then resume from saved pointer
    for (int i = 0; i < N; i++) begin tx[i] = 32'(100 + i); ty[i] = 32'hFFFF_FFFE; end
    hold = 1; req_valid = 4'hF; enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    repeat (3) step();
    req_valid = '0; hold = 0;
    repeat (3) step();

    // Reset pulsed with two ops in flight
    req_valid = 4'b0110;
    repeat (2) step();
    rst = 1'b0; q.delete(); m_ptr = 0;
    step();
    rst = 1'b1;
    repeat (2) step();
    hist.delete();
    req_valid = 4'hF;
    repeat (4) step();
    repeat (3) step();
    chk("first_after_rst", 64'(hist[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
